// File: rtl/ssd_share_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ssd_share_arbiter_if                                       |
// | Description : Bundle between display requesters and ssd_share_arbiter.   |
// |               master = requester side, slave = arbiter side.             |
// |   Req      NUM_REQ      level request, one bit per requester             |
// |   ReqData  16*NUM_REQ   four hex digits per requester, [16i+15:16i]      |
// |   ReqDP    4*NUM_REQ    decimal-point mask per requester, [4i+3:4i]      |
// |   Gnt      NUM_REQ      one-hot current owner, 0 when idle               |
// |   DataIn   16           digits toward FourSSD                            |
// |   SSD_DP   4            decimal points toward FourSSD                    |
// |   En       1            FourSSD enable, 1 only while an owner exists     |
// |   Busy     1            1 while the display is owned                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface ssd_share_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    Req;
  logic [16*NUM_REQ-1:0] ReqData;
  logic [4*NUM_REQ-1:0]  ReqDP;
  logic [NUM_REQ-1:0]    Gnt;
  logic [15:0]           DataIn;
  logic [3:0]            SSD_DP;
  logic                  En;
  logic                  Busy;

  modport master (
    output Req, ReqData, ReqDP,
    input  Gnt, DataIn, SSD_DP, En, Busy
  );

  modport slave (
    input  Req, ReqData, ReqDP,
    output Gnt, DataIn, SSD_DP, En, Busy
  );
endinterface
`default_nettype wire

// File: rtl/ssd_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ssd_share_arbiter                                          |
// | Description : Round-robin sharing of one FourSSD display among NUM_REQ   |
// |               requesters, with a minimum dwell time per owner. All       |
// |               outputs are registered.                                    |
// |   Clk    in  system clock, rising edge                                   |
// |   Rst_n  in  asynchronous active-low reset                               |
// |   bus    slave modport of ssd_share_arbiter_if (requests in, grant and    |
// |          display data out)                                               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ssd_share_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic                Clk,
  input  logic                Rst_n,
  ssd_share_arbiter_if.slave  bus
);

  localparam int                 c_IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [0:0]         c_IDLE     = 1'b0;
  localparam logic [0:0]         c_OWN      = 1'b1;
  localparam logic [CNT_W-1:0]   c_RELOAD   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_REQ - 1);

  logic [0:0]         r_state;
  logic [c_IDX_W-1:0] r_last;   // equals the current owner while in OWN
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [15:0]        r_data;
  logic [3:0]         r_dp;
  logic               r_en;
  logic               r_busy;

  logic [0:0]         w_state_nxt;
  logic [c_IDX_W-1:0] w_last_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [15:0]        w_data_nxt;
  logic [3:0]         w_dp_nxt;
  logic               w_en_nxt;
  logic               w_busy_nxt;

  logic               w_found;
  logic [c_IDX_W-1:0] w_winner;
  logic               w_owner_req;
  logic               w_take;
  logic               w_keep;

  // Round-robin search starting just after the last owner. The last owner is
  // checked last, so when only the owner is requesting it wins again, which
  // covers the "keep the owner and reload" case without a separate path.
  always_comb begin
    int v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && bus.Req[v_idx]) begin
        w_found  = 1'b1;
        w_winner = c_IDX_W'(v_idx);
      end
    end
  end

  assign w_owner_req = bus.Req[r_last];

  // A new grant is issued from IDLE, when the owner drops, or when the dwell
  // count has expired; otherwise an owner that still requests simply counts.
  assign w_take = w_found && ((r_state == c_IDLE) || !w_owner_req || (r_cnt == '0));
  assign w_keep = (r_state == c_OWN) && w_owner_req && (r_cnt != '0);

  // State register plus registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= c_IDLE;
      r_last  <= c_LAST_RST;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_data  <= '0;
      r_dp    <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_data  <= w_data_nxt;
      r_dp    <= w_dp_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_found) w_state_nxt = c_OWN;
      c_OWN:   if (!w_owner_req && !w_found) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    w_last_nxt = r_last;
    w_cnt_nxt  = '0;
    w_gnt_nxt  = '0;
    w_data_nxt = '0;
    w_dp_nxt   = '0;
    w_en_nxt   = 1'b0;
    w_busy_nxt = 1'b0;
    if (w_take) begin
      w_last_nxt = w_winner;
      w_cnt_nxt  = c_RELOAD;
      w_gnt_nxt  = NUM_REQ'(1) << w_winner;
      w_data_nxt = bus.ReqData[16*int'(w_winner) +: 16];
      w_dp_nxt   = bus.ReqDP[4*int'(w_winner) +: 4];
      w_en_nxt   = 1'b1;
      w_busy_nxt = 1'b1;
    end else if (w_keep) begin
      w_cnt_nxt  = r_cnt - 1'b1;
      w_gnt_nxt  = r_gnt;
      w_data_nxt = bus.ReqData[16*int'(r_last) +: 16];
      w_dp_nxt   = bus.ReqDP[4*int'(r_last) +: 4];
      w_en_nxt   = 1'b1;
      w_busy_nxt = 1'b1;
    end
  end

  assign bus.Gnt    = r_gnt;
  assign bus.DataIn = r_data;
  assign bus.SSD_DP = r_dp;
  assign bus.En     = r_en;
  assign bus.Busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ssd_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ssd_share_arbiter                                       |
// | Description : Self-checking bench for ssd_share_arbiter (NUM_REQ=4,      |
// |               DWELL_CYCLES=4): directed vector table, hand sequences and |
// |               randomized traffic against a reference model.              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ssd_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int CW = 3;

  logic Clk = 1'b0;
  logic Rst_n;

  always #5 Clk = ~Clk;

  ssd_share_arbiter_if #(.NUM_REQ(N)) bus ();

  ssd_share_arbiter #(
    .NUM_REQ      (N),
    .DWELL_CYCLES (DW),
    .CNT_W        (CW)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  exp_gnt;
    logic [15:0] exp_data;
    logic [3:0]  exp_dp;
    logic        exp_en;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] d_a;
  logic [63:0] d_b;
  logic [15:0] p_a;

  // Reference model state: owner index (-1 when idle), last owner, and how
  // many cycles the current owner has held the display so far.
  int          m_owner;
  int          m_last;
  int          m_held;
  logic [3:0]  m_gnt;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic        m_en;

  task automatic check(input string name, input logic [3:0] eg, input logic [15:0] ed,
                       input logic [3:0] ep, input logic ee);
    n_vec++;
    if (bus.Gnt !== eg || bus.DataIn !== ed || bus.SSD_DP !== ep ||
        bus.En !== ee || bus.Busy !== ee) begin
      n_bad++;
      $display("FAIL %s @%0t: got gnt=%b data=%h dp=%b en=%b busy=%b, want gnt=%b data=%h dp=%b en=%b busy=%b",
               name, $time, bus.Gnt, bus.DataIn, bus.SSD_DP, bus.En, bus.Busy, eg, ed, ep, ee, ee);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_held  = 0;
  endtask

  // One clock edge of the arbitration rules, using the inputs seen at that edge.
  task automatic model_step(input logic [3:0] req, input logic [63:0] d, input logic [15:0] p);
    if (m_owner < 0 || !req[m_owner] || m_held == DW) begin
      m_owner = rr_pick(req, m_last);
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_held = 1;
      end
    end else begin
      m_held++;
    end
    if (m_owner >= 0) begin
      m_gnt  = 4'(1 << m_owner);
      m_data = d[16*m_owner +: 16];
      m_dp   = p[4*m_owner +: 4];
      m_en   = 1'b1;
    end else begin
      m_gnt  = '0;
      m_data = '0;
      m_dp   = '0;
      m_en   = 1'b0;
    end
  endtask

  task automatic do_reset();
    Rst_n       = 1'b0;
    bus.Req     = '0;
    bus.ReqData = d_a;
    bus.ReqDP   = p_a;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("reset_state", 4'b0000, 16'h0000, 4'b0000, 1'b0);
    #2;
    Rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl[16];

  initial begin
    logic [3:0] r_req;
    int         own;

    d_a = 64'h3333_2222_1111_ABCD;
    d_b = 64'h3333_2222_FFFF_1234;
    p_a = 16'h8425;   // dp0=0101 dp1=0010 dp2=0100 dp3=1000

    // Directed table, one entry per clock, starting right after reset.
    tbl[0]  = '{4'b0000, d_a, 4'b0000, 16'h0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0001, d_a, 4'b0001, 16'hABCD, 4'b0101, 1'b1};
    tbl[2]  = '{4'b0001, d_a, 4'b0001, 16'hABCD, 4'b0101, 1'b1};
    tbl[3]  = '{4'b0001, d_a, 4'b0001, 16'hABCD, 4'b0101, 1'b1};
    tbl[4]  = '{4'b0001, d_a, 4'b0001, 16'hABCD, 4'b0101, 1'b1};
    tbl[5]  = '{4'b0001, d_a, 4'b0001, 16'hABCD, 4'b0101, 1'b1};  // sole requester keeps it
    tbl[6]  = '{4'b1111, d_a, 4'b0001, 16'hABCD, 4'b0101, 1'b1};
    tbl[7]  = '{4'b1111, d_a, 4'b0001, 16'hABCD, 4'b0101, 1'b1};
    tbl[8]  = '{4'b1111, d_a, 4'b0001, 16'hABCD, 4'b0101, 1'b1};
    tbl[9]  = '{4'b1111, d_a, 4'b0010, 16'h1111, 4'b0010, 1'b1};  // dwell over -> 1
    tbl[10] = '{4'b0100, d_a, 4'b0100, 16'h2222, 4'b0100, 1'b1};  // owner 1 drops on 2nd cycle
    tbl[11] = '{4'b0000, d_a, 4'b0000, 16'h0000, 4'b0000, 1'b0};  // all drop -> idle
    tbl[12] = '{4'b0101, d_a, 4'b0001, 16'hABCD, 4'b0101, 1'b1};  // search from 3 wraps to 0
    tbl[13] = '{4'b0101, d_b, 4'b0001, 16'h1234, 4'b0101, 1'b1};  // owner data follows, req1 ignored
    tbl[14] = '{4'b1000, d_b, 4'b1000, 16'h3333, 4'b1000, 1'b1};  // drop + new request = handoff
    tbl[15] = '{4'b0000, d_b, 4'b0000, 16'h0000, 4'b0000, 1'b0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.Req     = tbl[i].req;
      bus.ReqData = tbl[i].data;
      bus.ReqDP   = p_a;
      @(posedge Clk);
      #1;
      check($sformatf("table[%0d]", i), tbl[i].exp_gnt, tbl[i].exp_data, tbl[i].exp_dp, tbl[i].exp_en);
    end

    // Lone requester holds the display indefinitely.
    do_reset();
    bus.Req = 4'b0001;
    for (int c = 0; c < 44; c++) begin
      @(posedge Clk);
      #1;
      check("long_hold", 4'b0001, 16'hABCD, 4'b0101, 1'b1);
    end

    // Asynchronous reset between edges while owner 0 holds the display.
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_reset", 4'b0000, 16'h0000, 4'b0000, 1'b0);
    #2;
    Rst_n   = 1'b1;
    bus.Req = 4'b1111;
    @(posedge Clk);
    #1;
    check("post_reset_grant", 4'b0001, 16'hABCD, 4'b0101, 1'b1);

    // Full contention: owners 0,1,2,3,0 for exactly DW cycles each.
    do_reset();
    bus.Req = 4'b1111;
    for (int c = 0; c < 5 * DW; c++) begin
      @(posedge Clk);
      #1;
      own = (c / DW) % N;
      check("rr_rotation", 4'(1 << own), d_a[16*own +: 16], p_a[4*own +: 4], 1'b1);
    end

    // Randomized traffic against the reference model.
    do_reset();
    r_req = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) r_req = 4'($urandom);
      bus.Req     = r_req;
      bus.ReqData = {$urandom, $urandom};
      bus.ReqDP   = 16'($urandom);
      model_step(bus.Req, bus.ReqData, bus.ReqDP);
      @(posedge Clk);
      #1;
      check("random", m_gnt, m_data, m_dp, m_en);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
